// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: bit timing, bit stuffing, NRZI and EOP generation.
// Consumes a raw LSB-first bit stream and drives registered D+/D- levels.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_start,
    input  logic tx_valid,
    input  logic tx_bit,
    input  logic tx_last,
    output logic bit_taken,
    output logic tx_busy,
    output logic tx_done,
    output logic tx_error,
    output logic d_plus,
    output logic d_minus
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STUFF_RUN = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0_1,
        ST_EOP_SE0_2,
        ST_EOP_J
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    ones_r;
    logic          cur_last_r;
    logic          lvl_r;        // NRZI level: 1 = J, 0 = K

    logic          boundary_s;
    logic          in_bit_s;
    logic          stuff_due_s;
    logic          accept_s;
    logic          take_s;
    logic          underrun_s;
    logic          done_s;
    logic          nrzi_lvl_s;
    logic [2:0]    ones_nxt_s;

    // Map an NRZI level onto the differential pair; {1,1} is unreachable.
    function automatic logic [1:0] line_of(input logic lvl);
        line_of = {lvl, ~lvl};
    endfunction

    // Boundary detection, handshake strobes and next NRZI level for the presented bit.
    always_comb begin
        boundary_s  = 1'b0;
        in_bit_s    = 1'b0;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        stuff_due_s = (ones_r == STUFF_RUN);
        case (state_r)
            ST_IDLE: begin
                accept_s = tx_start & tx_valid;
            end
            ST_DATA, ST_STUFF: begin
                in_bit_s   = 1'b1;
                boundary_s = (cnt_r == CNT_MAX);
            end
            ST_EOP_SE0_1, ST_EOP_SE0_2: begin
                boundary_s = (cnt_r == CNT_MAX);
            end
            ST_EOP_J: begin
                boundary_s = (cnt_r == CNT_MAX);
                done_s     = boundary_s;
            end
            default: begin
                boundary_s = 1'b0;
            end
        endcase
        if (in_bit_s && boundary_s && !stuff_due_s && !cur_last_r) begin
            take_s     = accept_s | tx_valid;
            underrun_s = ~tx_valid;
        end else begin
            take_s     = accept_s;
            underrun_s = 1'b0;
        end
        if (tx_bit) begin
            nrzi_lvl_s = lvl_r;
            ones_nxt_s = ones_r + 3'd1;
        end else begin
            nrzi_lvl_s = ~lvl_r;
            ones_nxt_s = 3'd0;
        end
    end

    assign bit_taken = take_s;
    assign tx_error  = underrun_s;
    assign tx_done   = done_s;
    assign tx_busy   = (state_r != ST_IDLE);

    // Packet sequencer: bit timer, stuffing counter, NRZI state and registered line drivers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            ones_r     <= 3'd0;
            cur_last_r <= 1'b0;
            lvl_r      <= 1'b1;
            d_plus     <= 1'b1;
            d_minus    <= 1'b0;
        end else begin
            if (state_r == ST_IDLE || boundary_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r              <= ST_DATA;
                        cur_last_r           <= tx_last;
                        lvl_r                <= nrzi_lvl_s;
                        ones_r               <= ones_nxt_s;
                        {d_plus, d_minus}    <= line_of(nrzi_lvl_s);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA, ST_STUFF: begin
                    if (!boundary_s) begin
                        state_r <= state_r;
                    end else if (stuff_due_s) begin
                        state_r              <= ST_STUFF;
                        lvl_r                <= ~lvl_r;
                        ones_r               <= 3'd0;
                        {d_plus, d_minus}    <= line_of(~lvl_r);
                    end else if (cur_last_r || !tx_valid) begin
                        // Normal end of data and underrun abort share the same EOP path.
                        state_r              <= ST_EOP_SE0_1;
                        {d_plus, d_minus}    <= 2'b00;
                    end else begin
                        state_r              <= ST_DATA;
                        cur_last_r           <= tx_last;
                        lvl_r                <= nrzi_lvl_s;
                        ones_r               <= ones_nxt_s;
                        {d_plus, d_minus}    <= line_of(nrzi_lvl_s);
                    end
                end
                ST_EOP_SE0_1: begin
                    if (boundary_s) begin
                        state_r <= ST_EOP_SE0_2;
                    end else begin
                        state_r <= ST_EOP_SE0_1;
                    end
                end
                ST_EOP_SE0_2: begin
                    if (boundary_s) begin
                        state_r              <= ST_EOP_J;
                        lvl_r                <= 1'b1;
                        {d_plus, d_minus}    <= line_of(1'b1);
                    end else begin
                        state_r <= ST_EOP_SE0_2;
                    end
                end
                ST_EOP_J: begin
                    if (boundary_s) begin
                        state_r    <= ST_IDLE;
                        ones_r     <= 3'd0;
                        cur_last_r <= 1'b0;
                        lvl_r      <= 1'b1;
                    end else begin
                        state_r <= ST_EOP_J;
                    end
                end
                default: begin
                    state_r              <= ST_IDLE;
                    ones_r               <= 3'd0;
                    lvl_r                <= 1'b1;
                    {d_plus, d_minus}    <= line_of(1'b1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: directed vector table, hand-written reset/ignore sequences and
// random packets checked against a symbol-level model (stuffed bit list -> NRZI -> EOP).
module tb_usb_tx_encoder;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic tx_start = 1'b0;
    logic tx_valid = 1'b0;
    logic tx_bit = 1'b0;
    logic tx_last = 1'b0;
    logic bit_taken, tx_busy, tx_done, tx_error, d_plus, d_minus;

    int n_pass = 0;
    int n_total = 0;

    usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .tx_valid (tx_valid),
        .tx_bit   (tx_bit),
        .tx_last  (tx_last),
        .bit_taken(bit_taken),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .d_plus   (d_plus),
        .d_minus  (d_minus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          k;            // index of the bit withheld (underrun); k>=n means none
        int          exp_periods;  // bit periods from accept to tx_done, EOP included
        int          exp_taken;
        int          exp_err;      // cycle of tx_error after accept, -1 if none
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic run_packet(input string tag, input logic [31:0] bits, input int n,
                              input int k, input bit rnd, input int exp_periods,
                              input int exp_taken, input int exp_err);
        logic [1:0] sym[$];
        logic lvl;
        int ones, nsent, data_len, p, idx, taken;
        int done_cnt, done_cyc, err_cnt, err_cyc, line_bad, first_bad, busy_bad;
        sym = {};
        lvl = 1'b1;
        ones = 0;
        nsent = (k < n) ? k : n;
        for (int i = 0; i < nsent; i++) begin
            if (!bits[i]) lvl = ~lvl;
            sym.push_back({lvl, ~lvl});
            ones = bits[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                sym.push_back({lvl, ~lvl});
                ones = 0;
            end
        end
        data_len = sym.size();
        sym.push_back(2'b00);
        sym.push_back(2'b00);
        sym.push_back(2'b10);
        p = sym.size();

        @(negedge clk);
        tx_start = 1'b1;
        tx_valid = 1'b1;
        tx_bit   = bits[0];
        tx_last  = (n == 1);
        #1;
        check({tag, "/accept_taken"}, int'(bit_taken), 1);
        check({tag, "/accept_idle"}, int'({tx_busy, d_plus, d_minus}), 3'b010);
        idx = 1; taken = 1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        line_bad = 0; first_bad = -1; busy_bad = 0;
        for (int c = 1; c <= 8 * p; c++) begin
            @(negedge clk);
            tx_valid = (idx < n) && (idx != k);
            tx_bit   = (idx < 32) ? bits[idx] : 1'b0;
            tx_last  = (idx == n - 1);
            tx_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if ({d_plus, d_minus} !== sym[(c - 1) / 8]) begin
                if (line_bad == 0) first_bad = c;
                line_bad++;
            end
            if (tx_busy !== 1'b1) busy_bad++;
            if (bit_taken) begin taken++; idx++; end
            if (tx_done)  begin done_cnt++; done_cyc = c; end
            if (tx_error) begin err_cnt++; err_cyc = c; end
        end
        tx_start = 1'b0;
        tx_valid = 1'b0;
        if (line_bad != 0) $display("  %s first line deviation at cycle %0d", tag, first_bad);
        check({tag, "/line_errors"}, line_bad, 0);
        check({tag, "/busy_drops"}, busy_bad, 0);
        check({tag, "/taken_model"}, taken, nsent);
        check({tag, "/done_count"}, done_cnt, 1);
        check({tag, "/done_cycle_model"}, done_cyc, 8 * p);
        check({tag, "/error_count"}, err_cnt, (k < n) ? 1 : 0);
        check({tag, "/error_cycle_model"}, err_cyc, (k < n) ? 8 * data_len : -1);
        if (exp_periods > 0) begin
            check({tag, "/done_cycle_table"}, done_cyc, 8 * exp_periods);
            check({tag, "/taken_table"}, taken, exp_taken);
            check({tag, "/error_cycle_table"}, err_cyc, exp_err);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int strobes, busy_seen, line_bad;
        vecs[0] = '{bits: 32'h0000_0080, n: 8,  k: 8,  exp_periods: 11, exp_taken: 8,  exp_err: -1};
        vecs[1] = '{bits: 32'h0000_00FF, n: 8,  k: 8,  exp_periods: 12, exp_taken: 8,  exp_err: -1};
        vecs[2] = '{bits: 32'h0000_003F, n: 6,  k: 6,  exp_periods: 10, exp_taken: 6,  exp_err: -1};
        vecs[3] = '{bits: 32'h0000_0002, n: 5,  k: 2,  exp_periods: 5,  exp_taken: 2,  exp_err: 16};
        vecs[4] = '{bits: 32'h0000_0001, n: 1,  k: 1,  exp_periods: 4,  exp_taken: 1,  exp_err: -1};
        vecs[5] = '{bits: 32'h0000_0FFF, n: 12, k: 12, exp_periods: 17, exp_taken: 12, exp_err: -1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset/line", int'({d_plus, d_minus}), 2'b10);
        check("reset/busy", int'(tx_busy), 0);
        check("reset/strobes", int'({bit_taken, tx_done, tx_error}), 0);
        n_rst = 1'b1;

        // tx_start with tx_valid=0 in IDLE is ignored
        strobes = 0; busy_seen = 0; line_bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tx_start = 1'b1; tx_valid = 1'b0; tx_bit = c[0];
            #1;
            if (bit_taken | tx_done | tx_error) strobes++;
            if (tx_busy) busy_seen++;
            if ({d_plus, d_minus} !== 2'b10) line_bad++;
        end
        tx_start = 1'b0;
        check("ignore/strobes", strobes, 0);
        check("ignore/busy", busy_seen, 0);
        check("ignore/line", line_bad, 0);

        // Directed table (back-to-back: each accept lands the cycle after the previous tx_done)
        for (int v = 0; v < 6; v++)
            run_packet($sformatf("vec%0d", v), vecs[v].bits, vecs[v].n, vecs[v].k, 1'b0,
                       vecs[v].exp_periods, vecs[v].exp_taken, vecs[v].exp_err);

        // Reset asserted mid-bit aborts at once
        @(negedge clk);
        tx_start = 1'b1; tx_valid = 1'b1; tx_bit = 1'b0; tx_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        #3;
        check("midreset/busy_before", int'(tx_busy), 1);
        n_rst = 1'b0;
        #1;
        check("midreset/line", int'({d_plus, d_minus}), 2'b10);
        check("midreset/busy", int'(tx_busy), 0);
        tx_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        strobes = 0; busy_seen = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            #1;
            if (bit_taken | tx_done | tx_error) strobes++;
            if (tx_busy) busy_seen++;
        end
        check("midreset/strobes_after", strobes, 0);
        check("midreset/busy_after", busy_seen, 0);
        check("midreset/line_after", int'({d_plus, d_minus}), 2'b10);

        // Random packets with run-heavy data, random tx_start while busy, occasional underrun
        for (int r = 0; r < 24; r++) begin
            logic [31:0] b;
            int n, k;
            n = $urandom_range(1, 24);
            b = (r % 2 == 0) ? ($urandom | $urandom | $urandom) : $urandom;
            k = n;
            if (n > 1 && $urandom_range(0, 3) == 0) k = $urandom_range(1, n - 1);
            run_packet($sformatf("rnd%0d", r), b, n, k, 1'b1, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
